// File: rtl/reg_wb_arbiter_pkg.sv
// Shared constants and types for the writeback arbiter and its scoreboard.
package reg_wb_arbiter_pkg;

    localparam int REG_ADDR_W = 4;
    localparam int NUM_REGS   = 16;
    localparam int DATA_W     = 32;

    // Arbitration policy selected by the FIXED_PRIO parameter of the top.
    typedef enum logic {
        RR    = 1'b0,
        FIXED = 1'b1
    } arb_mode_e;

    // One-hot decode of a register address into a busy-vector mask.
    function automatic logic [NUM_REGS-1:0] rd_onehot(input logic [REG_ADDR_W-1:0] rd);
        logic [NUM_REGS-1:0] mask;
        mask     = '0;
        mask[rd] = 1'b1;
        return mask;
    endfunction

endpackage

// File: rtl/reg_wb_arbiter_scoreboard.sv
// In-flight destination tracking. A bit is set when decode reserves a
// register and cleared on the edge where the bank captures the write.
// Hazard queries also see writes that are granted or registered but not
// yet committed, so decode never reads a stale value.
module wb_scoreboard
    import reg_wb_arbiter_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush,
    input  logic                  rsv_valid,
    input  logic [REG_ADDR_W-1:0] rsv_rd,
    input  logic                  clr_valid,
    input  logic [REG_ADDR_W-1:0] clr_rd,
    input  logic                  pend_valid,
    input  logic [REG_ADDR_W-1:0] pend_rd,
    input  logic [REG_ADDR_W-1:0] rs1,
    input  logic [REG_ADDR_W-1:0] rs2,
    output logic                  rs1_busy,
    output logic                  rs2_busy,
    output logic [NUM_REGS-1:0]   busy_mask,
    output logic                  err_waw
);

    logic [NUM_REGS-1:0] busy_q;
    logic [NUM_REGS-1:0] busy_d;
    logic [NUM_REGS-1:0] set_vec;
    logic [NUM_REGS-1:0] clr_vec;
    logic                rsv_take;
    logic                waw_hit;

    // Next busy vector: clear the committing register, then apply the
    // reservation so a same-edge set wins. Register 0 never goes busy.
    always_comb begin
        set_vec  = '0;
        clr_vec  = '0;
        rsv_take = rsv_valid && !flush && (rsv_rd != '0);
        if (rsv_take) begin
            set_vec = rd_onehot(rsv_rd);
        end
        if (clr_valid) begin
            clr_vec = rd_onehot(clr_rd);
        end
        waw_hit = rsv_take && busy_q[rsv_rd] && !clr_vec[rsv_rd];
        if (flush) begin
            busy_d = '0;
        end else begin
            busy_d = (busy_q & ~clr_vec) | set_vec;
        end
        busy_d[0] = 1'b0;
    end

    // Busy vector and sticky write-after-write error flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q  <= '0;
            err_waw <= 1'b0;
        end else begin
            busy_q <= busy_d;
            if (waw_hit) begin
                err_waw <= 1'b1;
            end
        end
    end

    assign busy_mask = busy_q;

    assign rs1_busy = (rs1 != '0) &&
                      (busy_q[rs1] || (pend_valid && pend_rd == rs1) ||
                       (clr_valid && clr_rd == rs1));
    assign rs2_busy = (rs2 != '0) &&
                      (busy_q[rs2] || (pend_valid && pend_rd == rs2) ||
                       (clr_valid && clr_rd == rs2));

endmodule

// File: rtl/reg_wb_arbiter.sv
// Writeback arbiter: shares the register bank write port between the ALU
// (A) and load/memory (B) requesters and registers the winning write.
// Handshake: a transfer happens in any cycle where x_valid && x_ready;
// ready is a combinational grant, never high without valid, and at most
// one of a_ready/b_ready is high per cycle. Requesters hold rd/data stable
// while valid is high and ready is low.
module reg_wb_arbiter
    import reg_wb_arbiter_pkg::*;
#(
    parameter int FIXED_PRIO   = 0,
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        a_valid,
    output logic        a_ready,
    input  logic [3:0]  a_rd,
    input  logic [31:0] a_data,
    input  logic        b_valid,
    output logic        b_ready,
    input  logic [3:0]  b_rd,
    input  logic [31:0] b_data,
    input  logic        rsv_valid,
    input  logic [3:0]  rsv_rd,
    input  logic        flush,
    input  logic [3:0]  rs1,
    input  logic [3:0]  rs2,
    output logic        rs1_busy,
    output logic        rs2_busy,
    output logic        wb_we,
    output logic [3:0]  wb_rd,
    output logic [31:0] wb_data,
    output logic [15:0] busy_mask,
    output logic        err_waw
);

    localparam arb_mode_e MODE  = (FIXED_PRIO != 0) ? FIXED : RR;
    localparam int        CNT_W = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT);

    logic                  grant_a;
    logic                  grant_b;
    logic                  grant_valid;
    logic [REG_ADDR_W-1:0] grant_rd;
    logic [DATA_W-1:0]     grant_data;
    logic                  rr_favour_b;
    logic [CNT_W-1:0]      starve_cnt;

    // Grant selection; nothing is granted while reset is asserted.
    always_comb begin
        grant_a = 1'b0;
        grant_b = 1'b0;
        if (rst_n) begin
            if (a_valid && b_valid) begin
                if (MODE == FIXED) begin
                    if (starve_cnt == CNT_MAX) begin
                        grant_b = 1'b1;
                    end else begin
                        grant_a = 1'b1;
                    end
                end else begin
                    if (rr_favour_b) begin
                        grant_b = 1'b1;
                    end else begin
                        grant_a = 1'b1;
                    end
                end
            end else begin
                grant_a = a_valid;
                grant_b = b_valid;
            end
        end
    end

    assign a_ready     = grant_a;
    assign b_ready     = grant_b;
    assign grant_valid = grant_a || grant_b;
    assign grant_rd    = grant_b ? b_rd : a_rd;
    assign grant_data  = grant_b ? b_data : a_data;

    // Round-robin pointer: after a grant the other requester is favoured.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_favour_b <= 1'b0;
        end else if (grant_a) begin
            rr_favour_b <= 1'b1;
        end else if (grant_b) begin
            rr_favour_b <= 1'b0;
        end
    end

    // Starvation counter: consecutive cycles B waits, saturating at the limit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve_cnt <= '0;
        end else if (flush) begin
            starve_cnt <= '0;
        end else if (b_valid && !grant_b) begin
            if (starve_cnt != CNT_MAX) begin
                starve_cnt <= starve_cnt + 1'b1;
            end
        end else begin
            starve_cnt <= '0;
        end
    end

    // Output register to the bank; rd=0 grants are accepted but never written.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wb_we   <= 1'b0;
            wb_rd   <= '0;
            wb_data <= '0;
        end else begin
            wb_we <= grant_valid && (grant_rd != '0);
            if (grant_valid) begin
                wb_rd   <= grant_rd;
                wb_data <= grant_data;
            end
        end
    end

    wb_scoreboard u_scoreboard (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush      (flush),
        .rsv_valid  (rsv_valid),
        .rsv_rd     (rsv_rd),
        .clr_valid  (wb_we),
        .clr_rd     (wb_rd),
        .pend_valid (grant_valid),
        .pend_rd    (grant_rd),
        .rs1        (rs1),
        .rs2        (rs2),
        .rs1_busy   (rs1_busy),
        .rs2_busy   (rs2_busy),
        .busy_mask  (busy_mask),
        .err_waw    (err_waw)
    );

endmodule

// File: tb/tb_reg_wb_arbiter.sv
// Bench for reg_wb_arbiter: instance 0 is round-robin, instance 1 is
// fixed priority with starvation guard. Both are driven independently and
// compared every cycle against a behavioural model of the writeback rules.
module tb_reg_wb_arbiter;

    localparam int LIMIT = 4;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic        a_valid[2], b_valid[2], rsv_valid[2], flush[2];
    logic [3:0]  a_rd[2], b_rd[2], rsv_rd[2], rs1[2], rs2[2];
    logic [31:0] a_data[2], b_data[2];
    logic        a_ready[2], b_ready[2], rs1_busy[2], rs2_busy[2], wb_we[2], err_waw[2];
    logic [3:0]  wb_rd[2];
    logic [31:0] wb_data[2];
    logic [15:0] busy_mask[2];

    for (genvar gi = 0; gi < 2; gi++) begin : g_dut
        reg_wb_arbiter #(.FIXED_PRIO(gi), .STARVE_LIMIT(LIMIT)) dut (
            .clk(clk), .rst_n(rst_n),
            .a_valid(a_valid[gi]), .a_ready(a_ready[gi]), .a_rd(a_rd[gi]), .a_data(a_data[gi]),
            .b_valid(b_valid[gi]), .b_ready(b_ready[gi]), .b_rd(b_rd[gi]), .b_data(b_data[gi]),
            .rsv_valid(rsv_valid[gi]), .rsv_rd(rsv_rd[gi]), .flush(flush[gi]),
            .rs1(rs1[gi]), .rs2(rs2[gi]), .rs1_busy(rs1_busy[gi]), .rs2_busy(rs2_busy[gi]),
            .wb_we(wb_we[gi]), .wb_rd(wb_rd[gi]), .wb_data(wb_data[gi]),
            .busy_mask(busy_mask[gi]), .err_waw(err_waw[gi])
        );
    end

    // ---------------- reference model ----------------
    int          m_last[2];   // requester granted last: 1=A, 2=B
    int          m_wait[2];   // consecutive cycles B has waited, capped
    bit          m_we[2];
    logic [3:0]  m_rd[2];
    logic [31:0] m_data[2];
    logic [15:0] m_busy[2];
    bit          m_err[2];
    int          g[2];        // this cycle's winner: 0 none, 1 A, 2 B
    logic [3:0]  g_rd[2];
    logic [31:0] g_data[2];
    logic [35:0] exp_q[$];    // expected bank writes of instance 0

    int checks = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_last[i] = 2;
            m_wait[i] = 0;
            m_we[i]   = 1'b0;
            m_rd[i]   = '0;
            m_data[i] = '0;
            m_busy[i] = '0;
            m_err[i]  = 1'b0;
            g[i]      = 0;
        end
        exp_q.delete();
    endtask

    function automatic int pick(input int i);
        if (a_valid[i] && b_valid[i]) begin
            if (i == 0) return (m_last[i] == 1) ? 2 : 1;
            return (m_wait[i] == LIMIT) ? 2 : 1;
        end
        if (a_valid[i]) return 1;
        if (b_valid[i]) return 2;
        return 0;
    endfunction

    function automatic bit exp_busy(input int i, input logic [3:0] rs);
        if (rs == 0) return 1'b0;
        return m_busy[i][rs] || (g[i] != 0 && g_rd[i] == rs) || (m_we[i] && m_rd[i] == rs);
    endfunction

    // ---------------- driver tasks ----------------
    task automatic idle();
        for (int i = 0; i < 2; i++) begin
            a_valid[i] = 0; b_valid[i] = 0; rsv_valid[i] = 0; flush[i] = 0;
        end
    endtask

    // One clock cycle: inputs are already driven at the negedge.
    task automatic step();
        logic [15:0] nb;
        logic [35:0] e;
        #1;
        for (int i = 0; i < 2; i++) begin
            g[i]      = pick(i);
            g_rd[i]   = (g[i] == 2) ? b_rd[i] : a_rd[i];
            g_data[i] = (g[i] == 2) ? b_data[i] : a_data[i];
            check($sformatf("a_ready%0d", i), a_ready[i], g[i] == 1);
            check($sformatf("b_ready%0d", i), b_ready[i], g[i] == 2);
            check($sformatf("rs1_busy%0d", i), rs1_busy[i], exp_busy(i, rs1[i]));
            check($sformatf("rs2_busy%0d", i), rs2_busy[i], exp_busy(i, rs2[i]));
        end
        @(posedge clk);
        for (int i = 0; i < 2; i++) begin
            nb = m_busy[i];
            if (m_we[i]) nb[m_rd[i]] = 1'b0;
            if (flush[i]) begin
                nb = '0;
            end else if (rsv_valid[i] && rsv_rd[i] != 0) begin
                if (m_busy[i][rsv_rd[i]] && !(m_we[i] && m_rd[i] == rsv_rd[i])) m_err[i] = 1'b1;
                nb[rsv_rd[i]] = 1'b1;
            end
            m_busy[i] = nb;
            if (flush[i]) m_wait[i] = 0;
            else if (b_valid[i] && g[i] != 2) m_wait[i] = (m_wait[i] + 1 > LIMIT) ? LIMIT : m_wait[i] + 1;
            else m_wait[i] = 0;
            if (g[i] != 0) begin
                m_last[i] = g[i];
                m_rd[i]   = g_rd[i];
                m_data[i] = g_data[i];
                m_we[i]   = (g_rd[i] != 0);
            end else begin
                m_we[i] = 1'b0;
            end
            if (i == 0 && m_we[i]) exp_q.push_back({m_rd[i], m_data[i]});
        end
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            check($sformatf("wb_we%0d", i), wb_we[i], m_we[i]);
            check($sformatf("busy_mask%0d", i), busy_mask[i], m_busy[i]);
            check($sformatf("err_waw%0d", i), err_waw[i], m_err[i]);
            if (m_we[i]) begin
                check($sformatf("wb_rd%0d", i), wb_rd[i], m_rd[i]);
                check($sformatf("wb_data%0d", i), wb_data[i], m_data[i]);
            end
        end
        // scoreboard: every bank write of instance 0 must match the queue head
        if (wb_we[0]) begin
            if (exp_q.size() == 0) begin
                check("wb_unexpected", 1, 0);
            end else begin
                e = exp_q.pop_front();
                check("wb_stream", {wb_rd[0], wb_data[0]}, e);
            end
        end
    endtask

    task automatic check_all_zero(input string tag);
        for (int i = 0; i < 2; i++) begin
            check($sformatf("%s_wb_we%0d", tag, i), wb_we[i], 0);
            check($sformatf("%s_wb_rd%0d", tag, i), wb_rd[i], 0);
            check($sformatf("%s_wb_data%0d", tag, i), wb_data[i], 0);
            check($sformatf("%s_busy%0d", tag, i), busy_mask[i], 0);
            check($sformatf("%s_err%0d", tag, i), err_waw[i], 0);
            check($sformatf("%s_ready%0d", tag, i), {a_ready[i], b_ready[i]}, 0);
            check($sformatf("%s_rsbusy%0d", tag, i), {rs1_busy[i], rs2_busy[i]}, 0);
        end
    endtask

    // ---------------- stimulus ----------------
    int nb_grants;

    initial begin
        for (int i = 0; i < 2; i++) begin
            a_rd[i] = 0; b_rd[i] = 0; rsv_rd[i] = 0; rs1[i] = 0; rs2[i] = 0;
            a_data[i] = 0; b_data[i] = 0;
        end
        idle();
        rst_n = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        check_all_zero("reset");
        rst_n = 1'b1;

        // single write from A
        for (int i = 0; i < 2; i++) begin
            a_valid[i] = 1; a_rd[i] = 5; a_data[i] = 32'h1234;
        end
        step();
        idle();
        check("t1_wb_rd", wb_rd[0], 5);
        check("t1_wb_data", wb_data[0], 32'h1234);
        step();
        step();

        // both requesters continuously valid
        nb_grants = 0;
        for (int i = 0; i < 2; i++) begin
            a_valid[i] = 1; a_rd[i] = 3; a_data[i] = $urandom;
            b_valid[i] = 1; b_rd[i] = 4; b_data[i] = $urandom;
        end
        for (int k = 0; k < 10; k++) begin
            step();
            if (wb_we[1] && wb_rd[1] == 4) nb_grants++;
        end
        check("fixed_b_grants", nb_grants, 2);
        idle();
        step();

        // reservation on 7, committed through B
        for (int i = 0; i < 2; i++) begin
            rsv_valid[i] = 1; rsv_rd[i] = 7; rs1[i] = 7; rs2[i] = 0;
        end
        step();
        for (int i = 0; i < 2; i++) rsv_valid[i] = 0;
        step();
        for (int i = 0; i < 2; i++) begin
            b_valid[i] = 1; b_rd[i] = 7; b_data[i] = $urandom;
        end
        step();
        idle();
        step();
        step();
        check("t3_rs1_free", rs1_busy[0], 0);

        // double reservation of 9, then reserve 9 on its commit edge
        for (int i = 0; i < 2; i++) begin
            rsv_valid[i] = 1; rsv_rd[i] = 9;
        end
        step();
        step();
        check("t4_err", err_waw[0], 1);
        idle();
        for (int i = 0; i < 2; i++) begin
            a_valid[i] = 1; a_rd[i] = 9; a_data[i] = $urandom;
        end
        step();
        idle();
        for (int i = 0; i < 2; i++) begin
            rsv_valid[i] = 1; rsv_rd[i] = 9;
        end
        step();
        check("t4_busy9", busy_mask[0][9], 1);
        idle();

        // rd=0 write, then flush of a 0x00A0 mask
        for (int i = 0; i < 2; i++) begin
            a_valid[i] = 1; a_rd[i] = 0; a_data[i] = $urandom;
        end
        step();
        idle();
        for (int i = 0; i < 2; i++) flush[i] = 1;
        step();
        idle();
        for (int i = 0; i < 2; i++) begin rsv_valid[i] = 1; rsv_rd[i] = 5; end
        step();
        for (int i = 0; i < 2; i++) rsv_rd[i] = 7;
        step();
        idle();
        check("t5_mask", busy_mask[0], 16'h00A0);
        for (int i = 0; i < 2; i++) flush[i] = 1;
        step();
        idle();
        check("t5_flushed", busy_mask[0], 0);

        // reset in the middle of traffic
        for (int i = 0; i < 2; i++) begin
            a_valid[i] = 1; a_rd[i] = 2; a_data[i] = $urandom;
            b_valid[i] = 1; b_rd[i] = 6; b_data[i] = $urandom;
            rsv_valid[i] = 1; rsv_rd[i] = 11; rs1[i] = 2; rs2[i] = 6;
        end
        step();
        step();
        rst_n = 1'b0;
        #1;
        check_all_zero("midrst");
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        idle();
        step();

        // randomized traffic respecting the hold rule
        for (int k = 0; k < 400; k++) begin
            for (int i = 0; i < 2; i++) begin
                if (!(a_valid[i] && g[i] != 1)) begin
                    a_valid[i] = ($urandom_range(0, 9) < 6);
                    a_rd[i]    = 4'($urandom_range(0, 15));
                    a_data[i]  = $urandom;
                end
                if (!(b_valid[i] && g[i] != 2)) begin
                    b_valid[i] = ($urandom_range(0, 9) < 6);
                    b_rd[i]    = 4'($urandom_range(0, 15));
                    b_data[i]  = $urandom;
                end
                rsv_valid[i] = ($urandom_range(0, 3) == 0);
                rsv_rd[i]    = 4'($urandom_range(0, 15));
                flush[i]     = ($urandom_range(0, 31) == 0);
                rs1[i]       = 4'($urandom_range(0, 15));
                rs2[i]       = 4'($urandom_range(0, 15));
            end
            step();
        end
        idle();
        step();
        step();
        check("exp_q_empty", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/reg_wb_arbiter.md
Name: reg_wb_arbiter

Overview:
- Shares the register bank's single write port between two writeback requesters: A (ALU) and B (load/memory).
- Tracks in-flight destination registers in a 16-entry scoreboard so decode can stall on read-after-write hazards.
- Sits between the execute/memory stages and the register bank; drives the bank's rd / write_data / reg_write inputs directly.

Parameters:
- FIXED_PRIO, 0, 0 = round-robin between A and B; 1 = A has fixed priority, with a starvation guard for B.
- STARVE_LIMIT, 4, in fixed-priority mode, consecutive cycles B may wait with b_valid high before B is forced to win.

Ports:
- clk  in  1  system clock; all state updates on posedge.
- rst_n  in  1  asynchronous reset, active-low.
- a_valid  in  1  requester A has a write pending.
- a_ready  out  1  A accepted this cycle; combinational grant.
- a_rd  in  4  A destination register.
- a_data  in  32  A write data.
- b_valid  in  1  requester B has a write pending.
- b_ready  out  1  B accepted this cycle; combinational grant.
- b_rd  in  4  B destination register.
- b_data  in  32  B write data.
- rsv_valid  in  1  decode reserves a destination register at issue.
- rsv_rd  in  4  register being reserved.
- flush  in  1  synchronous clear of the scoreboard and starvation counter.
- rs1  in  4  hazard query address 1.
- rs2  in  4  hazard query address 2.
- rs1_busy  out  1  rs1 has an uncommitted write; combinational.
- rs2_busy  out  1  rs2 has an uncommitted write; combinational.
- wb_we  out  1  registered write enable to the bank.
- wb_rd  out  4  registered destination to the bank.
- wb_data  out  32  registered write data to the bank.
- busy_mask  out  16  scoreboard state, bit n = register n busy.
- err_waw  out  1  sticky flag: reservation made on an already-busy register.

Behaviour:
- Reset (rst_n=0, asynchronous): wb_we=0, wb_rd=0, wb_data=0, busy_mask=0, err_waw=0, starvation counter=0, round-robin pointer favours A.
- Handshake: a transfer occurs when x_valid && x_ready. At most one grant per cycle. ready is never asserted when the matching valid is low.
- Requesters must hold rd and data stable while valid is high and ready is low.
- Arbitration, round-robin: if only one requester is valid, it wins. If both are valid, the one not granted last wins. The pointer updates only on a grant.
- Arbitration, fixed: A wins when both are valid, except when the counter equals STARVE_LIMIT; then B wins.
  - The counter increments each cycle b_valid && !b_ready, saturating at STARVE_LIMIT.
  - It clears when B is granted or b_valid is low.
- Latency: a grant at edge N loads wb_we/wb_rd/wb_data at edge N, so they are visible in cycle N+1. The bank writes at edge N+1. Back-to-back grants give one write per cycle.
- With no grant, wb_we=0 on the next cycle; wb_rd and wb_data hold their previous values.
- rd=0 writes: accepted (ready asserted) but wb_we stays 0. Register 0 is never written or marked busy.
- Scoreboard set: rsv_valid && rsv_rd!=0 sets busy[rsv_rd] at the edge.
  - If that bit is already set and is not being cleared at the same edge, err_waw is set (sticky until reset).
- Scoreboard clear: bit wb_rd clears at the edge where wb_we=1, i.e. the edge the bank captures the data.
- Same register set and cleared at one edge: set wins, bit stays 1, no err_waw.
- rsN_busy = busy[rsN] || (a grant this cycle targets rsN != 0) || (wb_we && wb_rd==rsN). Query address 0 always returns 0.
- flush=1: busy_mask and the starvation counter clear at the edge. A grant and wb_* update in the same cycle still proceed normally. A reservation in the flush cycle is ignored. err_waw is unaffected.
- Reset mid-operation: every output returns to its reset value immediately. The in-flight write is lost, and requesters must re-present it.

Decomposition:
- Shared package holds the constants REG_ADDR_W=4, NUM_REGS=16 and DATA_W=32, plus an arbiter-mode enum (RR, FIXED).
- Sub-module wb_scoreboard holds the 16-bit busy vector, set/clear/flush logic, err_waw and the combinational query ports.
- The arbiter, starvation counter and output register stay in the top module.

Test Plan:
- Reset, then a_valid with a_rd=5, a_data=0x1234 -> a_ready=1 the same cycle; next cycle wb_we=1, wb_rd=5, wb_data=0x1234; following cycle wb_we=0.
- FIXED_PRIO=0, A and B valid continuously with rd 3 and 4 -> grants alternate A,B,A,B; wb_rd sequence 3,4,3,4 with no idle cycles.
- FIXED_PRIO=1, STARVE_LIMIT=4, A and B both valid continuously -> A granted 4 cycles, B granted on the 5th, then the pattern repeats.
- rsv rd=7; then rs1=7 -> rs1_busy=1 until the edge where wb_we=1 with wb_rd=7 (write via B); rs1_busy=0 the cycle after. Query rs2=0 -> always 0.
- rsv rd=9 twice with no intervening write -> err_waw=1 and stays 1. Repeat with rsv rd=9 at the edge where wb_we=1, wb_rd=9 -> busy[9]=1, err_waw unchanged.
- A write with rd=0 -> a_ready=1, wb_we stays 0. Assert flush while busy_mask=0x00A0 -> busy_mask=0 next cycle. Drop rst_n mid-stream -> all outputs 0 immediately.
